// File: rtl/icache_fetcher.sv
// Instruction fetcher with a direct-mapped, one-instruction-per-line cache in front of
// program memory, plus invalidate and saturating hit/miss counters.
module icache_fetcher #(
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
  parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
  parameter int unsigned PC_BITS               = 8,
  parameter int unsigned CACHE_LINES           = 8,
  parameter int unsigned CNT_BITS              = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PC_BITS-1:0]               current_pc,
  input  logic                             invalidate,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [CNT_BITS-1:0]              hit_count,
  output logic [CNT_BITS-1:0]              miss_count
);

  localparam int unsigned IDX_BITS = $clog2(CACHE_LINES);
  localparam int unsigned TAG_BITS = PC_BITS - IDX_BITS;
  localparam logic [2:0]  CoreFetch  = 3'b001;
  localparam logic [2:0]  CoreDecode = 3'b010;

  typedef enum logic [2:0] {
    StIdle     = 3'b000,
    StFetching = 3'b001,
    StFetched  = 3'b010,
    StLookup   = 3'b011
  } state_e;

  state_e                             r_state, w_state_next;
  logic [PC_BITS-1:0]                 r_req_pc;
  logic [CACHE_LINES-1:0]             r_valid;
  logic [TAG_BITS-1:0]                r_tag  [CACHE_LINES];
  logic [PROGRAM_MEM_DATA_BITS-1:0]   r_line [CACHE_LINES];
  logic                               r_poison;
  logic                               r_mem_valid;
  logic [PROGRAM_MEM_ADDR_BITS-1:0]   r_mem_addr;
  logic [PROGRAM_MEM_DATA_BITS-1:0]   r_instr;
  logic [CNT_BITS-1:0]                r_hit_cnt, r_miss_cnt;

  logic [IDX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0] w_tag;
  logic                w_hit, w_lookup, w_fill;

  assign w_idx    = r_req_pc[IDX_BITS-1:0];
  assign w_tag    = r_req_pc[PC_BITS-1:IDX_BITS];
  assign w_lookup = (r_state == StLookup);
  // A coincident invalidate forces the lookup to miss.
  assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag) && !invalidate;
  assign w_fill   = (r_state == StFetching) && mem_read_ready;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:     if (core_state == CoreFetch) w_state_next = StLookup;
      StLookup:   w_state_next = w_hit ? StFetched : StFetching;
      StFetching: if (mem_read_ready) w_state_next = StFetched;
      StFetched:  if (core_state == CoreDecode) w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_req_pc    <= '0;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_instr     <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_valid     <= '0;
      r_poison    <= 1'b0;
    end else begin
      if (r_state == StIdle && core_state == CoreFetch) r_req_pc <= current_pc;
      if (w_lookup) begin
        if (w_hit) begin
          r_instr <= r_line[w_idx];
          if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_BITS'(1);
        end else begin
          r_mem_valid <= 1'b1;
          r_mem_addr  <= PROGRAM_MEM_ADDR_BITS'(r_req_pc);
          if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_BITS'(1);
        end
      end
      if (w_fill) begin
        r_instr     <= mem_read_data;
        r_mem_valid <= 1'b0;
      end
      // Poison marks an in-flight fill that must not be cached; it dies with the fetch.
      r_poison <= (r_state == StFetching) && !mem_read_ready && (r_poison || invalidate);
      if (invalidate)                r_valid        <= '0;
      else if (w_fill && !r_poison)  r_valid[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill && !r_poison && !invalidate) begin
      r_line[w_idx] <= mem_read_data;
      r_tag[w_idx]  <= w_tag;
    end
  end

  assign fetcher_state    = r_state;
  assign mem_read_valid   = r_mem_valid;
  assign mem_read_address = r_mem_addr;
  assign instruction      = r_instr;
  assign hit_count        = r_hit_cnt;
  assign miss_count       = r_miss_cnt;

endmodule

// File: tb/tb_icache_fetcher.sv
// Randomized scoreboard bench for icache_fetcher: a per-index "cached pc" model predicts
// hit/miss, data and counters; a negedge monitor pops expectations on entry to FETCHED.
module tb_icache_fetcher;

  localparam int LINES = 8;
  localparam int CNT   = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        invalidate;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [3:0]  hit_count, miss_count;

  icache_fetcher #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .PROGRAM_MEM_DATA_BITS(16),
    .PC_BITS(8),
    .CACHE_LINES(LINES),
    .CNT_BITS(CNT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .core_state(core_state),
    .current_pc(current_pc),
    .invalidate(invalidate),
    .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data),
    .fetcher_state(fetcher_state),
    .instruction(instruction),
    .hit_count(hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hit;
    logic [15:0] instr;
    logic [3:0]  hc;
    logic [3:0]  mc;
    logic [7:0]  addr;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_fail = 0;

  logic        m_valid [LINES];
  logic [7:0]  m_pc    [LINES];
  logic [15:0] m_data  [LINES];
  logic [15:0] mem_img [256];
  int          m_hc, m_mc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  logic [2:0]  prev_st = 3'b000;
  logic [15:0] last_instr = 16'h0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!reset) begin
      if (fetcher_state == 3'b001 && exp_q.size() > 0) begin
        check("req_valid", 32'(mem_read_valid), 32'd1);
        check("req_addr", 32'(mem_read_address), 32'(exp_q[0].addr));
      end
      if (fetcher_state == 3'b010) begin
        check("fetched_no_req", 32'(mem_read_valid), 32'd0);
        if (prev_st != 3'b010) begin
          if (exp_q.size() == 0) begin
            check("unexpected_fetched", 32'd1, 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check("path", 32'(prev_st), mon_e.hit ? 32'd3 : 32'd1);
            check("instr", 32'(instruction), 32'(mon_e.instr));
            check("hit_count", 32'(hit_count), 32'(mon_e.hc));
            check("miss_count", 32'(miss_count), 32'(mon_e.mc));
            last_instr = mon_e.instr;
          end
        end else begin
          check("hold_instr", 32'(instruction), 32'(last_instr));
        end
      end
    end
    prev_st = fetcher_state;
  end

  task automatic model_clear_valid();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_reset();
    model_clear_valid();
    m_hc = 0;
    m_mc = 0;
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    core_state = 3'b000;
    invalidate = 1'b0;
    mem_read_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
  endtask

  function automatic logic [2:0] idle_val();
    logic [2:0] v;
    v = 3'($urandom_range(0, 7));
    if (v == 3'b001 || v == 3'b010) v = 3'b000;
    return v;
  endfunction

  // mode: 0 plain, 1 invalidate at LOOKUP, 2 invalidate mid-FETCHING, 3 invalidate on fill edge
  task automatic fetch(input logic [7:0] pc, input int mode, input int dly);
    int   idx;
    logic hit;
    exp_t e;
    idx = int'(pc) % LINES;
    hit = m_valid[idx] && (m_pc[idx] == pc) && (mode != 1);
    if (mode == 1) model_clear_valid();
    if (hit) begin if (m_hc < 15) m_hc++; end
    else     begin if (m_mc < 15) m_mc++; end
    e.hit   = hit;
    e.instr = hit ? m_data[idx] : mem_img[pc];
    e.hc    = 4'(m_hc);
    e.mc    = 4'(m_mc);
    e.addr  = pc;
    exp_q.push_back(e);

    core_state = 3'b001;
    current_pc = pc;
    @(posedge clk);
    #1 core_state = idle_val();
    current_pc = 8'($urandom);
    if (mode == 1) invalidate = 1'b1;
    @(posedge clk);
    #1 invalidate = 1'b0;
    if (!hit) begin
      if (mode == 2 && dly == 0) dly = 1;
      for (int k = 0; k < dly; k++) begin
        if (mode == 2 && k == 0) invalidate = 1'b1;
        @(posedge clk);
        #1 invalidate = 1'b0;
      end
      mem_read_ready = 1'b1;
      mem_read_data  = mem_img[pc];
      if (mode == 3) invalidate = 1'b1;
      @(posedge clk);
      #1 mem_read_ready = 1'b0;
      invalidate    = 1'b0;
      mem_read_data = 16'($urandom);
      if (mode == 2 || mode == 3) begin
        model_clear_valid();
      end else begin
        m_valid[idx] = 1'b1;
        m_pc[idx]    = pc;
        m_data[idx]  = mem_img[pc];
      end
    end
    @(posedge clk);
    #1 core_state = 3'b010;
    @(posedge clk);
    #1 core_state = idle_val();
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(posedge clk);
    #1 check("drain", 32'(exp_q.size()), 32'd0);
    if (exp_q.size() != 0) do_reset();
  endtask

  task automatic pulse_inv();
    invalidate = 1'b1;
    @(posedge clk);
    #1 invalidate = 1'b0;
    model_clear_valid();
  endtask

  task automatic reset_mid_fetch(input logic [7:0] pc);
    pulse_inv();
    core_state = 3'b001;
    current_pc = pc;
    @(posedge clk);
    #1 core_state = 3'b000;
    @(posedge clk);
    #1;
    check("midfetch_req", 32'(mem_read_valid), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    check("rst_state", 32'(fetcher_state), 32'd0);
    check("rst_req", 32'(mem_read_valid), 32'd0);
    check("rst_miss", 32'(miss_count), 32'd0);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'hDEAD;
    @(posedge clk);
    #1 mem_read_ready = 1'b0;
    check("stray_state", 32'(fetcher_state), 32'd0);
    check("stray_instr", 32'(instruction), 32'd0);
    check("stray_req", 32'(mem_read_valid), 32'd0);
  endtask

  initial begin
    int r, m;
    reset = 1'b1;
    core_state = 3'b000;
    current_pc = 8'h00;
    invalidate = 1'b0;
    mem_read_ready = 1'b0;
    mem_read_data = 16'h0;
    for (int i = 0; i < 256; i++) mem_img[i] = 16'($urandom);
    mem_img[8'h03] = 16'hA5A5;
    mem_img[8'h0B] = 16'h1234;
    do_reset();

    check("reset_state", 32'(fetcher_state), 32'd0);
    check("reset_req", 32'(mem_read_valid), 32'd0);
    check("reset_addr", 32'(mem_read_address), 32'd0);
    check("reset_instr", 32'(instruction), 32'd0);
    check("reset_hits", 32'(hit_count), 32'd0);
    check("reset_misses", 32'(miss_count), 32'd0);

    fetch(8'h03, 0, 2);             // cold miss
    fetch(8'h03, 0, 0);             // hit
    fetch(8'h0B, 0, 1);             // conflict evicts 0x03
    fetch(8'h03, 0, 0);             // miss again
    check("conflict_misses", 32'(miss_count), 32'd3);
    pulse_inv();
    fetch(8'h03, 0, 1);             // miss after invalidate
    fetch(8'h05, 2, 2);             // invalidate during fill
    fetch(8'h05, 0, 0);             // must miss
    fetch(8'h05, 0, 0);             // now hits
    fetch(8'h06, 3, 1);             // invalidate on fill edge
    fetch(8'h06, 0, 0);
    fetch(8'h07, 1, 0);             // invalidate at lookup forces miss
    fetch(8'h07, 0, 0);
    reset_mid_fetch(8'h09);

    fetch(8'h01, 0, 0);
    for (int i = 0; i < 17; i++) fetch(8'h01, 0, 0);
    check("hit_saturate", 32'(hit_count), 32'hF);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5) pulse_inv();
      else if (r < 8) reset_mid_fetch(8'($urandom));
      else begin
        m = $urandom_range(0, 19);
        fetch(8'($urandom_range(0, 23)), (m < 17) ? 0 : m - 16, $urandom_range(0, 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_fetcher.md
Name: icache_fetcher

Overview:
Per-core instruction fetcher with a small direct-mapped instruction cache in front of program memory.
- Handshakes with the core scheduler through `core_state` and `fetcher_state`, using the existing FETCH/DECODE encoding.
- Cache hits return without a memory transaction; misses issue one program-memory read and fill the line.
- Adds software/host invalidate and hit/miss performance counters.

Parameters:
- PROGRAM_MEM_ADDR_BITS, 8: program memory address width; must be >= PC_BITS.
- PROGRAM_MEM_DATA_BITS, 16: instruction width.
- PC_BITS, 8: width of `current_pc`.
- CACHE_LINES, 8: number of one-instruction lines; power of two, 2..2^(PC_BITS-1). IDX_BITS = log2(CACHE_LINES).
- CNT_BITS, 16: width of the performance counters.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high
- core_state  input  3  core state; 3'b001 = FETCH, 3'b010 = DECODE
- current_pc  input  PC_BITS  PC to fetch
- invalidate  input  1  clear all cache lines
- mem_read_valid  output  1  program memory read request
- mem_read_address  output  PROGRAM_MEM_ADDR_BITS  read address (zero-extended PC)
- mem_read_ready  input  1  read data valid this cycle
- mem_read_data  input  PROGRAM_MEM_DATA_BITS  read data
- fetcher_state  output  3  IDLE = 000, FETCHING = 001, FETCHED = 010, LOOKUP = 011
- instruction  output  PROGRAM_MEM_DATA_BITS  fetched instruction; valid in FETCHED
- hit_count  output  CNT_BITS  saturating hit counter
- miss_count  output  CNT_BITS  saturating miss counter

Behaviour:
- Reset applies to every output and all storage:
  - `fetcher_state` = IDLE; `mem_read_valid` = 0; `mem_read_address`, `instruction`, both counters = 0.
  - All valid bits cleared; `poison` = 0.
  - Line data/tag arrays need no reset.
- Address split: index = req_pc[IDX_BITS-1:0]; tag = req_pc[PC_BITS-1:IDX_BITS].
- IDLE:
  - If `core_state` == FETCH: latch `current_pc` into req_pc, go to LOOKUP.
  - Any other `core_state` value: stay in IDLE.
- LOOKUP (exactly 1 cycle):
  - Hit (valid[index], tag match, `invalidate` low): `instruction` <= line data; increment `hit_count`; go to FETCHED.
  - Otherwise miss: `mem_read_valid` <= 1; `mem_read_address` <= zero-extended req_pc; increment `miss_count`; go to FETCHING.
- FETCHING:
  - `mem_read_valid` and `mem_read_address` held stable until `mem_read_ready`.
  - On `mem_read_ready`: `instruction` <= `mem_read_data`; `mem_read_valid` <= 0; go to FETCHED.
  - Same edge: write data/tag to the line and set its valid bit, unless `poison` is set or `invalidate` is high this cycle.
- FETCHED: hold `instruction`; when `core_state` == DECODE, go to IDLE.
- Latency (FETCH first sampled at edge N):
  - LOOKUP visible after edge N.
  - Hit: FETCHED after edge N+1.
  - Miss: `mem_read_valid` high after edge N+1; FETCHED on the edge after the `mem_read_ready` sample.
- invalidate:
  - Clears all valid bits at the next edge, in any state.
  - In FETCHING it also sets `poison`. The in-flight fill still delivers `instruction` but is not cached.
  - `poison` clears on leaving FETCHING.
  - Invalidate coincident with a LOOKUP forces a miss.
  - Invalidate coincident with a fill edge: invalidate wins, line stays invalid.
- Conflict: a fill overwrites any prior line at that index (direct-mapped eviction).
- Counters: +1 per LOOKUP outcome; saturate at all-ones (no wrap).
- Reset mid-FETCHING:
  - `mem_read_valid` is 0 after the reset edge.
  - A late `mem_read_ready` while in IDLE is ignored and causes no state change.

Test Plan:
- Cold miss: reset, pc = 0x03, FETCH → `mem_read_valid` = 1, address = 0x03; ready with data 0xA5A5 after 2 cycles → FETCHED, `instruction` = 0xA5A5, miss_count = 1; DECODE → IDLE.
- Hit: repeat pc = 0x03 → no `mem_read_valid` pulse, FETCHED 2 edges after FETCH, `instruction` = 0xA5A5, hit_count = 1.
- Conflict (CACHE_LINES = 8): fetch 0x0B (data 0x1234), then 0x03 → 0x03 misses again and re-reads memory; miss_count = 3.
- Invalidate: after the 0x03 fill, pulse `invalidate` in IDLE, fetch 0x03 → miss. Then `invalidate` during FETCHING of 0x05 → `instruction` delivered; next fetch of 0x05 misses.
- Reset mid-fetch: reset asserted while FETCHING → `mem_read_valid` = 0 and state IDLE next cycle; stray `mem_read_ready` in IDLE → no change.
- Saturation (CNT_BITS = 4): 17 hits → hit_count = 4'hF.
